// File: rtl/input_conditioner_pkg.sv
// Shared helpers for the input conditioner: counter width derivation.
package input_conditioner_pkg;

   // Width needed to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conditioner_channel.sv
// One input channel: 2-flop sync, counter debounce, edge pulses and long-press detection.
module conditioner_channel
   import input_conditioner_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 65536,
   parameter int unsigned HOLD_CYCLES   = 50000000,
   parameter bit          INVERT        = 1'b0,
   parameter bit          RESET_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dirty_i,
   input  logic enable_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o,
   output logic held_o,
   output logic hold_pulse_o
);

   localparam int unsigned SW = cnt_width(STABLE_CYCLES);
   localparam int unsigned HW = cnt_width(HOLD_CYCLES + 1);
   localparam logic [SW-1:0] StableMax = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HoldMax   = HW'(HOLD_CYCLES);

   logic          s1_q, s2_q, level;
   logic [SW-1:0] stable_q, stable_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
   logic          held_q, held_d, hold_pulse_q, hold_pulse_d;

   assign level = s2_q ^ INVERT;

   always_comb begin
      stable_d     = '0;
      clean_d      = clean_q;
      rise_d       = 1'b0;
      fall_d       = 1'b0;
      hold_d       = hold_q;
      held_d       = held_q;
      hold_pulse_d = 1'b0;
      if (enable_i) begin
         if (level != clean_q) begin
            if (stable_q == StableMax) begin
               clean_d = level;
               rise_d  = level;
               fall_d  = ~level;
            end else begin
               stable_d = stable_q + 1'b1;
            end
         end
         // Clearing on the next clean level makes held drop on the same edge as fall.
         if (!clean_d) begin
            hold_d = '0;
            held_d = 1'b0;
         end else if (clean_q && (hold_q != HoldMax)) begin
            hold_d = hold_q + 1'b1;
            if (hold_d == HoldMax) begin
               held_d       = 1'b1;
               hold_pulse_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q         <= RESET_VALUE ^ INVERT;
         s2_q         <= RESET_VALUE ^ INVERT;
         stable_q     <= '0;
         hold_q       <= '0;
         clean_q      <= RESET_VALUE;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         held_q       <= 1'b0;
         hold_pulse_q <= 1'b0;
      end else begin
         s1_q         <= dirty_i;
         s2_q         <= s1_q;
         stable_q     <= stable_d;
         hold_q       <= hold_d;
         clean_q      <= clean_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         held_q       <= held_d;
         hold_pulse_q <= hold_pulse_d;
      end
   end

   assign clean_o      = clean_q;
   assign rise_o       = rise_q;
   assign fall_o       = fall_q;
   assign held_o       = held_q;
   assign hold_pulse_o = hold_pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one independent conditioner_channel per pin.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int unsigned          CHANNELS      = 8,
   parameter int unsigned          STABLE_CYCLES = 65536,
   parameter int unsigned          HOLD_CYCLES   = 50000000,
   parameter logic [CHANNELS-1:0]  INVERT        = '0,
   parameter logic [CHANNELS-1:0]  RESET_VALUE   = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] dirty_i,
   input  logic [CHANNELS-1:0] enable_i,
   output logic [CHANNELS-1:0] clean_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o,
   output logic [CHANNELS-1:0] held_o,
   output logic [CHANNELS-1:0] hold_pulse_o
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      conditioner_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .INVERT        (INVERT[i]),
         .RESET_VALUE   (RESET_VALUE[i])
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .dirty_i      (dirty_i[i]),
         .enable_i     (enable_i[i]),
         .clean_o      (clean_o[i]),
         .rise_o       (rise_o[i]),
         .fall_o       (fall_o[i]),
         .held_o       (held_o[i]),
         .hold_pulse_o (hold_pulse_o[i])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a rule-level reference model.
module tb_input_conditioner;

   localparam int unsigned N   = 4;
   localparam int unsigned S   = 4;
   localparam int unsigned H   = 10;
   localparam logic [N-1:0] INV = 4'b0100;
   localparam logic [N-1:0] RV  = 4'b0000;

   logic         clk, rst_n;
   logic [N-1:0] dirty, enable;
   logic [N-1:0] clean, rise, fall, held, hold_pulse;

   input_conditioner #(
      .CHANNELS      (N),
      .STABLE_CYCLES (S),
      .HOLD_CYCLES   (H),
      .INVERT        (INV),
      .RESET_VALUE   (RV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dirty_i      (dirty),
      .enable_i     (enable),
      .clean_o      (clean),
      .rise_o       (rise),
      .fall_o       (fall),
      .held_o       (held),
      .hold_pulse_o (hold_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: pin history, accepted level, run of disagreeing samples, time high.
   logic [N-1:0] m_p1, m_p2, m_clean, m_rise, m_fall, m_held, m_hp;
   int           m_run  [N];
   int           m_high [N];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p1 = RV ^ INV;
      m_p2 = RV ^ INV;
      m_clean = RV;
      m_rise = '0; m_fall = '0; m_held = '0; m_hp = '0;
      for (int i = 0; i < N; i++) begin
         m_run[i]  = 0;
         m_high[i] = 0;
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] lv;
      logic         old_clean, old_held;
      lv = m_p2 ^ INV;
      m_p2 = m_p1;
      m_p1 = dirty;
      m_rise = '0; m_fall = '0; m_hp = '0;
      for (int i = 0; i < N; i++) begin
         old_clean = m_clean[i];
         old_held  = m_held[i];
         if (!enable[i]) begin
            m_run[i] = 0;
         end else begin
            if (lv[i] != m_clean[i]) begin
               m_run[i]++;
               if (m_run[i] == S) begin
                  m_clean[i] = lv[i];
                  m_run[i]   = 0;
                  m_rise[i]  = lv[i];
                  m_fall[i]  = ~lv[i];
               end
            end else begin
               m_run[i] = 0;
            end
            if (!m_clean[i]) m_high[i] = 0;
            else if (old_clean) m_high[i] = (m_high[i] + 1 > H) ? H : m_high[i] + 1;
            m_held[i] = (m_high[i] >= H);
            m_hp[i]   = m_held[i] && !old_held;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".clean"}, 32'(clean), 32'(m_clean));
      check({tag, ".rise"},  32'(rise),  32'(m_rise));
      check({tag, ".fall"},  32'(fall),  32'(m_fall));
      check({tag, ".held"},  32'(held),  32'(m_held));
      check({tag, ".hpulse"}, 32'(hold_pulse), 32'(m_hp));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all("cyc");
   endtask

   // sel: 0 clean, 1 rise, 2 fall, 3 held. n = ticks taken, budget+1 on timeout.
   task automatic wait_for(input int sel, input int ch, input int budget, output int n);
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n <= budget) begin
         tick();
         n++;
         case (sel)
            0: hit = clean[ch];
            1: hit = rise[ch];
            2: hit = fall[ch];
            default: hit = held[ch];
         endcase
      end
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all("async_rst");
      @(posedge clk);
      @(negedge clk);
      compare_all("in_rst");
      rst_n = 1'b1;
   endtask

   initial begin
      int n, cnt;
      rst_n  = 1'b0;
      dirty  = 4'b0100;
      enable = 4'hF;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;
      repeat (3) tick();

      // Step on channel 0: accepted after sync plus STABLE samples
      dirty[0] = 1'b1;
      wait_for(0, 0, 20, n);
      check("t1_latency", 32'(n), 32'd6);
      check("t1_rise", 32'(rise), 32'b0001);

      // Long press on channel 0
      wait_for(3, 0, 30, n);
      check("t4_hold_time", 32'(n), 32'd10);
      check("t4_hpulse", 32'(hold_pulse[0]), 32'd1);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         cnt += int'(hold_pulse[0]);
      end
      check("t4_no_repeat", 32'(cnt), 32'd0);
      dirty[0] = 1'b0;
      wait_for(2, 0, 20, n);
      check("t4_fall_lat", 32'(n), 32'd6);
      check("t4_held_clr", 32'(held[0]), 32'd0);

      // Short glitches on channel 1 never qualify
      cnt = 0;
      for (int r = 0; r < 3; r++) begin
         dirty[1] = 1'b1;
         repeat (3) begin tick(); cnt += int'(rise[1]) + int'(clean[1]); end
         dirty[1] = 1'b0;
         tick();
         cnt += int'(rise[1]) + int'(clean[1]);
      end
      repeat (3) begin tick(); cnt += int'(rise[1]) + int'(clean[1]); end
      check("t2_glitch", 32'(cnt), 32'd0);
      dirty[1] = 1'b1;
      wait_for(1, 1, 20, n);
      check("t2_rise_lat", 32'(n), 32'd6);

      // Inverted channel 2: pin released low means active
      check("t3_idle", 32'(clean[2]), 32'd0);
      dirty[2] = 1'b0;
      wait_for(1, 2, 20, n);
      check("t3_rise_lat", 32'(n), 32'd6);

      // Disabled channel 3 ignores activity, then qualifies from zero
      enable[3] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         dirty[3] = (i == 19) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         cnt += int'(rise[3]) + int'(fall[3]) + int'(hold_pulse[3]) + int'(clean[3]);
      end
      repeat (3) begin tick(); cnt += int'(rise[3]) + int'(clean[3]); end
      check("t5_disabled", 32'(cnt), 32'd0);
      enable[3] = 1'b1;
      wait_for(1, 3, 20, n);
      check("t5_rise_lat", 32'(n), 32'd4);

      // Reset mid-qualification (ch0) and while channel 1 is held
      dirty[0] = 1'b1;
      repeat (4) tick();
      apply_reset();
      check("t6_clean_rst", 32'(clean), 32'(RV));
      wait_for(0, 0, 20, n);
      check("t6_requal", 32'(n), 32'd6);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) dirty[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) enable[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 999) == 0) apply_reset();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
